// File: rtl/ls_port_arbiter.sv
// Local-store port arbiter: grants one of ls / dma / if per cycle onto the single-port SRAM,
// with DMA burst locking, fetch starvation override and flush cancellation of ls load returns.
module ls_port_arbiter #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    input  logic              ls_flush,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_burst,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BCNT_W = $clog2(MAX_BURST) + 1;
    localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, BURST, YIELD} state_t;

    state_t             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               ls_rvalid_q, ls_rvalid_d;
    logic               dma_rvalid_q, dma_rvalid_d;
    logic               if_rvalid_q, if_rvalid_d;
    logic               starve;

    assign starve = if_req && (scnt_q == SCNT_W'(STARVE_LIMIT));

    // Grants are forced low during reset so nothing issued in that cycle can return data.
    always_comb begin
        ls_gnt  = 1'b0;
        dma_gnt = 1'b0;
        if_gnt  = 1'b0;
        if (!reset) begin
            if (starve)                          if_gnt  = 1'b1;
            else if (state_q == BURST && dma_req) dma_gnt = 1'b1;
            else if (ls_req)                     ls_gnt  = 1'b1;
            else if (dma_req && state_q != YIELD) dma_gnt = 1'b1;
            else if (if_req)                     if_gnt  = 1'b1;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_we    = ls_we;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    assign mem_en = ls_gnt | dma_gnt | if_gnt;
    assign rdata  = mem_rdata;

    always_comb begin
        ls_rvalid_d  = ls_gnt && !ls_we && !ls_flush;
        dma_rvalid_d = dma_gnt && !dma_we;
        if_rvalid_d  = if_gnt;
        if (if_req && !if_gnt)
            scnt_d = (scnt_q == SCNT_W'(STARVE_LIMIT)) ? scnt_q : scnt_q + SCNT_W'(1);
        else
            scnt_d = '0;
    end

    // A starvation grant steals the BURST cycle without consuming a beat.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            IDLE: begin
                if (dma_gnt && dma_burst) begin
                    state_d = BURST;
                    bcnt_d  = BCNT_W'(1);
                end
            end
            BURST: begin
                if (starve) begin
                    state_d = BURST;
                end else if (!dma_req || !dma_burst) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end else if (bcnt_q < BCNT_W'(MAX_BURST - 1)) begin
                    bcnt_d  = bcnt_q + BCNT_W'(1);
                end else begin
                    state_d = YIELD;
                end
            end
            YIELD: begin
                state_d = (dma_req && dma_burst) ? BURST : IDLE;
                bcnt_d  = '0;
            end
            default: begin
                state_d = IDLE;
                bcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            scnt_q       <= '0;
            ls_rvalid_q  <= 1'b0;
            dma_rvalid_q <= 1'b0;
            if_rvalid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            scnt_q       <= scnt_d;
            ls_rvalid_q  <= ls_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            if_rvalid_q  <= if_rvalid_d;
        end
    end

    // Flush in the return cycle cancels a load granted the cycle before.
    assign ls_rvalid  = ls_rvalid_q && !ls_flush && !reset;
    assign dma_rvalid = dma_rvalid_q && !reset;
    assign if_rvalid  = if_rvalid_q && !reset;

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Directed self-checking bench for ls_port_arbiter: one task per scenario, inline comparisons.
module tb_ls_port_arbiter;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              ls_req, ls_we, ls_flush;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt, ls_rvalid;
    logic              dma_req, dma_we, dma_burst;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt, dma_rvalid;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt, if_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    ls_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4), .STARVE_LIMIT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_flush(ls_flush),
        .dma_req(dma_req), .dma_we(dma_we), .dma_burst(dma_burst), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ls_req = 0; ls_we = 0; ls_flush = 0; ls_addr = '0; ls_wdata = '0;
        dma_req = 0; dma_we = 0; dma_burst = 0; dma_addr = '0; dma_wdata = '0;
        if_req = 0; if_addr = '0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        ls_req = 1; dma_req = 1; if_req = 1;
        tick(); tick(); #1;
        tests++; if ({ls_gnt, dma_gnt, if_gnt} !== 3'b000) begin fails++; $display("FAIL reset_gnt got=%b exp=000", {ls_gnt, dma_gnt, if_gnt}); end
        tests++; if (mem_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        tests++; if ({ls_rvalid, dma_rvalid, if_rvalid} !== 3'b000) begin fails++; $display("FAIL reset_rvalid got=%b exp=000", {ls_rvalid, dma_rvalid, if_rvalid}); end
        tick(); reset = 0; clear_inputs(); #1;
        tests++; if ({ls_rvalid, dma_rvalid, if_rvalid} !== 3'b000) begin fails++; $display("FAIL reset_no_return got=%b exp=000", {ls_rvalid, dma_rvalid, if_rvalid}); end
    endtask

    task automatic test_ls_load();
        logic [DATA_W-1:0] pat;
        pat = {4{32'hCAFEF00D}};
        tick(); ls_req = 1; ls_we = 0; ls_addr = 11'h010; #1;
        tests++; if ({ls_gnt, dma_gnt, if_gnt, mem_en} !== 4'b1001) begin fails++; $display("FAIL load_gnt got=%b exp=1001", {ls_gnt, dma_gnt, if_gnt, mem_en}); end
        tests++; if (mem_addr !== 11'h010 || mem_we !== 1'b0) begin fails++; $display("FAIL load_mem addr=%h we=%b exp=010/0", mem_addr, mem_we); end
        tick(); ls_req = 0; mem_rdata = pat; #1;
        tests++; if ({ls_rvalid, dma_rvalid, if_rvalid} !== 3'b100) begin fails++; $display("FAIL load_rvalid got=%b exp=100", {ls_rvalid, dma_rvalid, if_rvalid}); end
        tests++; if (rdata !== pat) begin fails++; $display("FAIL load_rdata got=%h exp=%h", rdata, pat); end
        tests++; if (mem_en !== 1'b0 || mem_addr !== '0 || mem_we !== 1'b0 || mem_wdata !== '0) begin fails++; $display("FAIL idle_mem en=%b addr=%h exp=0/0", mem_en, mem_addr); end
        mem_rdata = '0;
    endtask

    task automatic test_ls_dma();
        tick();
        ls_req = 1; ls_we = 1; ls_addr = 11'h055; ls_wdata = 128'h1111;
        dma_req = 1; dma_we = 1; dma_burst = 0; dma_addr = 11'h7FF; dma_wdata = 128'h2222; #1;
        tests++; if ({ls_gnt, dma_gnt} !== 2'b10) begin fails++; $display("FAIL lsdma_first got=%b exp=10", {ls_gnt, dma_gnt}); end
        tests++; if (mem_we !== 1'b1 || mem_wdata !== 128'h1111) begin fails++; $display("FAIL lsdma_ls_mem we=%b wdata=%h exp=1/1111", mem_we, mem_wdata); end
        tick(); ls_req = 0; #1;
        tests++; if ({ls_gnt, dma_gnt} !== 2'b01) begin fails++; $display("FAIL lsdma_second got=%b exp=01", {ls_gnt, dma_gnt}); end
        tests++; if (mem_addr !== 11'h7FF || mem_wdata !== 128'h2222) begin fails++; $display("FAIL dma_wrap_hi addr=%h wdata=%h exp=7ff/2222", mem_addr, mem_wdata); end
        tick(); dma_we = 0; dma_addr = 11'h000; #1;
        tests++; if (dma_gnt !== 1'b1 || mem_addr !== 11'h000 || mem_we !== 1'b0) begin fails++; $display("FAIL dma_wrap_lo gnt=%b addr=%h we=%b exp=1/000/0", dma_gnt, mem_addr, mem_we); end
        tick(); dma_req = 0; #1;
        tests++; if ({ls_rvalid, dma_rvalid} !== 2'b01) begin fails++; $display("FAIL dma_read_rvalid got=%b exp=01", {ls_rvalid, dma_rvalid}); end
        clear_inputs();
    endtask

    task automatic test_burst();
        int exp_dma [8] = '{1, 1, 1, 1, 0, 1, 1, 0};
        int exp_ls  [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        int beat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ls_req = (i >= 1); ls_we = 1; ls_addr = ADDR_W'(11'h100 + i);
            dma_req = (beat < 6); dma_burst = (beat < 5); dma_we = 1;
            dma_addr = ADDR_W'(11'h200 + beat);
            #1;
            tests++; if (dma_gnt !== exp_dma[i][0] || ls_gnt !== exp_ls[i][0]) begin
                fails++; $display("FAIL burst_c%0d dma=%b ls=%b exp=%0d/%0d", i, dma_gnt, ls_gnt, exp_dma[i], exp_ls[i]);
            end
            if (exp_dma[i] == 1) begin
                tests++; if (mem_addr !== ADDR_W'(11'h200 + beat)) begin fails++; $display("FAIL burst_addr_c%0d got=%h exp=%h", i, mem_addr, 11'h200 + beat); end
                beat++;
            end
        end
        tick(); clear_inputs();
    endtask

    task automatic test_starve();
        for (int i = 0; i < 10; i++) begin
            tick();
            ls_req = 1; ls_we = 1; dma_req = 1; dma_we = 1; dma_burst = 0;
            if_req = 1; if_addr = 11'h300; #1;
            tests++; if (if_gnt !== (i == 8) || ls_gnt !== (i != 8)) begin
                fails++; $display("FAIL starve_c%0d if=%b ls=%b exp_if=%0d", i, if_gnt, ls_gnt, (i == 8));
            end
            if (i == 8) begin
                tests++; if (mem_addr !== 11'h300 || mem_we !== 1'b0) begin fails++; $display("FAIL starve_mem addr=%h we=%b exp=300/0", mem_addr, mem_we); end
            end
            if (i == 9) begin
                tests++; if (if_rvalid !== 1'b1) begin fails++; $display("FAIL starve_if_rvalid got=%b exp=1", if_rvalid); end
            end
        end
        tick(); clear_inputs();
    endtask

    task automatic test_flush();
        tick(); ls_req = 1; ls_we = 0; ls_addr = 11'h020; #1;
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL flush_load_gnt got=%b exp=1", ls_gnt); end
        tick(); ls_flush = 1; ls_addr = 11'h021; #1;
        tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL flush_cancel got=%b exp=0", ls_rvalid); end
        tests++; if (ls_gnt !== 1'b1) begin fails++; $display("FAIL flush_no_block got=%b exp=1", ls_gnt); end
        tick(); ls_flush = 0; ls_we = 1; ls_addr = 11'h022; #1;
        tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL flush_same_cycle got=%b exp=0", ls_rvalid); end
        tick(); ls_flush = 1; ls_addr = 11'h023; ls_wdata = 128'h3333; #1;
        tests++; if (ls_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 128'h3333) begin fails++; $display("FAIL flush_store gnt=%b we=%b exp=1/1", ls_gnt, mem_we); end
        tick(); clear_inputs(); #1;
        tests++; if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL flush_store_no_rvalid got=%b exp=0", ls_rvalid); end
    endtask

    task automatic test_reset_midburst();
        tick(); dma_req = 1; dma_we = 0; dma_burst = 1; dma_addr = 11'h400; #1;
        tests++; if (dma_gnt !== 1'b1) begin fails++; $display("FAIL mid_b0 got=%b exp=1", dma_gnt); end
        tick(); dma_addr = 11'h401; #1;
        tests++; if (dma_gnt !== 1'b1) begin fails++; $display("FAIL mid_b1 got=%b exp=1", dma_gnt); end
        tick(); reset = 1; dma_addr = 11'h402; #1;
        tests++; if ({ls_gnt, dma_gnt, if_gnt, mem_en, dma_rvalid} !== 5'b0) begin fails++; $display("FAIL mid_reset got=%b exp=00000", {ls_gnt, dma_gnt, if_gnt, mem_en, dma_rvalid}); end
        tick(); reset = 0; ls_req = 1; ls_we = 0; ls_addr = 11'h040; #1;
        tests++; if ({ls_gnt, dma_gnt, dma_rvalid} !== 3'b100) begin fails++; $display("FAIL post_reset got=%b exp=100", {ls_gnt, dma_gnt, dma_rvalid}); end
        tick(); ls_req = 0; #1;
        tests++; if ({dma_gnt, ls_rvalid} !== 2'b11) begin fails++; $display("FAIL post_reset_dma got=%b exp=11", {dma_gnt, ls_rvalid}); end
        tick(); clear_inputs(); #1;
        tests++; if (dma_rvalid !== 1'b1) begin fails++; $display("FAIL post_reset_rvalid got=%b exp=1", dma_rvalid); end
    endtask

    initial begin
        test_reset();
        test_ls_load();
        test_ls_dma();
        test_burst();
        test_starve();
        test_flush();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
